proc_rdy_scan: RTL and testbench
================================

Name: proc_rdy_scan

Overview:
- Reader-side counterpart to the process timer block. Consumes the per-process ready lines driven by the timers and turns them into a CPU-readable event queue.
- Captures rising edges of each ready line into sticky pending bits and gates them with a per-process enable mask.
- A round-robin scanner selects the next ready process. The scheduler reads the selected process number from an IO address; the read consumes that event.

Parameters:
- NUM_PROC, 16, number of process ready lines scanned (1..31).
- IDX_W, 5, width of the process index field (must satisfy 2**IDX_W >= NUM_PROC).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- rd  in  1  IO read strobe, one cycle per access.
- wr  in  1  IO write strobe, one cycle per access.
- addr  in  1  register select: 0 = NEXT/CTRL, 1 = STATUS/MASK.
- data_in  in  32  write data.
- proc_rdy  in  NUM_PROC  ready lines from the process timers.
- data_out  out  32  read data; combinational from registered state.
- irq  out  1  high while a selected event is waiting to be read.

Behaviour:
- Input stage:
  - rdy_q <= proc_rdy every cycle.
  - edge[i] = proc_rdy[i] & ~rdy_q[i].
  - pending[i] is set by edge[i].
- Writes:
  - addr 0: data_in[0] clears all pending bits. data_in[1] resets the round-robin pointer to NUM_PROC-1. Other bits are ignored.
  - addr 1: mask <= data_in[NUM_PROC-1:0].
- Candidate set: cand = pending & mask.
- FSM states IDLE, SCAN, FOUND:
  - IDLE: idx <= ptr. Go to SCAN when |cand.
  - SCAN: idx advances by one per cycle, wrapping from NUM_PROC-1 to 0, starting at ptr+1. If cand[idx] is set, sel <= idx and go to FOUND. If cand becomes 0, return to IDLE. Worst-case latency from pending set to FOUND is NUM_PROC+1 cycles.
  - FOUND: irq = 1, sel held. If mask[sel] or pending[sel] drops (masked or cleared), go to SCAN without consuming the event.
- Read addr 0 (NEXT):
  - data_out = {valid, 26'b0, sel} where valid = (state == FOUND).
  - In FOUND, rd consumes the event at the next edge: pending[sel] <= 0, ptr <= sel, state -> SCAN.
  - Outside FOUND, rd returns valid = 0 and has no side effect.
- Read addr 1 (STATUS): data_out = pending zero-extended; bit 31 is OVF, or 0 without the option. Non-destructive.
- Simultaneous events:
  - An edge on sel in the same cycle as its consuming read leaves pending[sel] = 1; the new event is kept.
  - An edge in the same cycle as clear-all also wins; that bit stays set.
  - rd and wr in the same cycle are both honoured. The read sees pre-write state.
- Reset values: pending = 0, mask = 0 (all disabled), rdy_q = 0, ptr = NUM_PROC-1, idx = 0, sel = 0, state = IDLE, irq = 0, data_out = 0.
- Reset mid-scan or in FOUND: everything returns to reset values; any unread event is lost.
- Fairness: after serving process k, the search starts at k+1, so no enabled process is starved.

Optional Feature:
- Macro: PROC_RDY_SCAN_OVF_EN.
- With the macro:
  - ovf[i] is set when edge[i] occurs while pending[i] is already 1 and not being consumed in that cycle.
  - STATUS bit 31 = |ovf.
  - CTRL write data_in[2] clears all ovf bits.
- Without the macro: no ovf registers, STATUS bit 31 reads 0, data_in[2] is ignored.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE = 2'd0, SCAN = 2'd1, FOUND = 2'd2.
  - Register address constants ADDR_NEXT_CTRL = 0 and ADDR_STATUS_MASK = 1.
  - CTRL bit positions CLR_ALL = 0, RST_PTR = 1, CLR_OVF = 2.
  - VALID bit position 31.
- One natural sub-module, rr_scan_fsm: holds the idx/ptr/sel counters and the state machine. Takes cand and a consume input; outputs sel and found.

Test Plan:
- Reset, then mask = 0xFFFF, pulse proc_rdy[3] high for 2 cycles -> FOUND within 5 cycles, irq = 1. Read NEXT -> 0x80000003, and pending[3] = 0 next cycle.
- Pend 2, 5, 9 simultaneously with ptr = 15 -> successive NEXT reads return 2, 5, 9. A further read returns valid = 0.
- mask = 0x0010, pend bits 1 and 4 -> only 4 is served. STATUS still reads 0x00000012 before the read and 0x00000002 after it.
- In FOUND with sel = 7, write mask bit 7 = 0 -> irq drops within 1 cycle. The scanner finds the next candidate or returns to IDLE; pending[7] stays set.
- Edge on line 6 in the same cycle as the consuming NEXT read of sel = 6 -> pending[6] stays 1 and 6 is served again after the other candidates.
- With PROC_RDY_SCAN_OVF_EN: two edges on line 0 with no read between -> STATUS = 0x80000001. CTRL write 0x4 -> STATUS = 0x00000001.

Source files
------------

// File: rtl/proc_rdy_scan_pkg.sv
// proc_rdy_scan shared types: FSM encoding, register map, CTRL bits.
// No ports; imported by proc_rdy_scan and its scanner FSM.
package proc_rdy_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    FOUND = 2'd2
  } state_e;

  localparam logic ADDR_NEXT_CTRL   = 1'b0;
  localparam logic ADDR_STATUS_MASK = 1'b1;

  localparam int CLR_ALL   = 0;
  localparam int RST_PTR   = 1;
  localparam int CLR_OVF   = 2;
  localparam int VALID_BIT = 31;

endpackage

// File: rtl/proc_rdy_scan_rr_scan_fsm.sv
// Round-robin scanner: walks cand from ptr+1, latches sel, holds FOUND.
// Ports: clk, rst, cand, consume, rst_ptr in; sel, found out.
module proc_rdy_scan_rr_scan_fsm
  import proc_rdy_scan_pkg::*;
#(
  parameter int NUM_PROC = 16,
  parameter int IDX_W    = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_PROC-1:0] cand,
  input  logic                consume,
  input  logic                rst_ptr,
  output logic [IDX_W-1:0]    sel,
  output logic                found
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_PROC - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic [IDX_W-1:0]   nxt;
  logic [2**IDX_W-1:0] cand_ext;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    ptr_d    = ptr_q;
    sel_d    = sel_q;
    cand_ext = '0;
    cand_ext[NUM_PROC-1:0] = cand;
    nxt = (idx_q == LAST) ? '0 : idx_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        idx_d = ptr_q;
        if (|cand) state_d = SCAN;
      end
      SCAN: begin
        if (!(|cand)) begin
          state_d = IDLE;
        end else begin
          idx_d = nxt;
          if (cand_ext[nxt]) begin
            sel_d   = nxt;
            state_d = FOUND;
          end
        end
      end
      FOUND: begin
        // idx already equals sel, so a rescan resumes at sel+1
        if (consume) begin
          ptr_d   = sel_q;
          state_d = SCAN;
        end else if (!cand_ext[sel_q]) begin
          state_d = SCAN;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst_ptr) ptr_d = LAST;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ptr_q   <= LAST;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
    end
  end

  assign sel   = sel_q;
  assign found = (state_q == FOUND);

endmodule

// File: rtl/proc_rdy_scan.sv
// Ready-line edge capture, masking and NEXT/STATUS IO; PROC_RDY_SCAN_OVF_EN adds ovf.
// Ports: clk, rst, rd, wr, addr, data_in, proc_rdy in; data_out, irq out.
module proc_rdy_scan
  import proc_rdy_scan_pkg::*;
#(
  parameter int NUM_PROC = 16,
  parameter int IDX_W    = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rd,
  input  logic                wr,
  input  logic                addr,
  input  logic [31:0]         data_in,
  input  logic [NUM_PROC-1:0] proc_rdy,
  output logic [31:0]         data_out,
  output logic                irq
);

  logic [NUM_PROC-1:0] rdy_q;
  logic [NUM_PROC-1:0] pend_q, pend_d;
  logic [NUM_PROC-1:0] mask_q, mask_d;
  logic [NUM_PROC-1:0] rise, cand;
  logic [NUM_PROC-1:0] sel_oh, cons_oh, clr;
  logic [IDX_W-1:0]    sel;
  logic                found, consume;
  logic                ctrl_wr, mask_wr;
  logic                ovf_any;
  logic                unused_data;

  assign unused_data = ^data_in;

  always_comb begin
    rise    = proc_rdy & ~rdy_q;
    cand    = pend_q & mask_q;
    ctrl_wr = wr & (addr == ADDR_NEXT_CTRL);
    mask_wr = wr & (addr == ADDR_STATUS_MASK);
    consume = rd & (addr == ADDR_NEXT_CTRL) & found;
    sel_oh  = '0;
    for (int i = 0; i < NUM_PROC; i++) begin
      sel_oh[i] = (sel == IDX_W'(i));
    end
    cons_oh = sel_oh & {NUM_PROC{consume}};
    clr     = cons_oh |
              {NUM_PROC{ctrl_wr & data_in[CLR_ALL]}};
    // a new edge beats any clear in the same cycle
    pend_d  = (pend_q & ~clr) | rise;
    mask_d  = mask_wr ? data_in[NUM_PROC-1:0] : mask_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_q  <= '0;
      pend_q <= '0;
      mask_q <= '0;
    end else begin
      rdy_q  <= proc_rdy;
      pend_q <= pend_d;
      mask_q <= mask_d;
    end
  end

`ifdef PROC_RDY_SCAN_OVF_EN
  logic [NUM_PROC-1:0] ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q &
            ~{NUM_PROC{ctrl_wr & data_in[CLR_OVF]}};
    ovf_d = ovf_d | (rise & pend_q & ~cons_oh);
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= '0;
    else     ovf_q <= ovf_d;
  end

  assign ovf_any = |ovf_q;
`else
  assign ovf_any = 1'b0;
`endif

  proc_rdy_scan_rr_scan_fsm #(
    .NUM_PROC (NUM_PROC),
    .IDX_W    (IDX_W)
  ) u_fsm (
    .clk     (clk),
    .rst     (rst),
    .cand    (cand),
    .consume (consume),
    .rst_ptr (ctrl_wr & data_in[RST_PTR]),
    .sel     (sel),
    .found   (found)
  );

  always_comb begin
    data_out = '0;
    if (addr == ADDR_NEXT_CTRL) begin
      data_out[IDX_W-1:0]     = sel;
      data_out[VALID_BIT]     = found;
    end else begin
      data_out[NUM_PROC-1:0]  = pend_q;
      data_out[VALID_BIT]     = ovf_any;
    end
  end

  assign irq = found;

endmodule

// File: tb/tb_proc_rdy_scan.sv
// Scoreboard bench for proc_rdy_scan against a selection-level model.
// Stimulus pushes expected reads; a negedge monitor pops and compares.
module tb_proc_rdy_scan;

  localparam int NP     = 16;
  localparam int SETTLE = NP + 4;

  logic          clk = 1'b0;
  logic          rst, rd, wr, addr;
  logic [31:0]   data_in, data_out;
  logic [NP-1:0] proc_rdy;
  logic          irq;

  proc_rdy_scan #(.NUM_PROC(NP), .IDX_W(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .rd       (rd),
    .wr       (wr),
    .addr     (addr),
    .data_in  (data_in),
    .proc_rdy (proc_rdy),
    .data_out (data_out),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        irq;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // model: pending/mask sets, last-served pointer, latched selection
  bit [NP-1:0] m_pend, m_mask, m_ovf;
  int          m_ptr, m_sel;
  bit          m_found;

  function automatic int rr_first(bit [NP-1:0] c, int start);
    for (int k = 1; k <= NP; k++) begin
      int j;
      j = (start + k) % NP;
      if (c[j]) return j;
    end
    return -1;
  endfunction

  function automatic void m_reset();
    m_pend  = '0;
    m_mask  = '0;
    m_ovf   = '0;
    m_ptr   = NP - 1;
    m_sel   = 0;
    m_found = 1'b0;
  endfunction

  function automatic void m_apply(bit r, bit w, bit a,
                                  logic [31:0] d, bit [NP-1:0] p);
    bit [NP-1:0] cb, clr, c;
    bit          cons, resume;
    int          start, j;
    cb     = '0;
    cons   = r && !a && m_found;
    resume = 1'b0;
    start  = 0;
    if (cons) cb[m_sel] = 1'b1;
`ifdef PROC_RDY_SCAN_OVF_EN
    if (w && !a && d[2]) m_ovf = '0;
    m_ovf = m_ovf | (p & m_pend & ~cb);
`endif
    clr    = cb | ((w && !a && d[0]) ? '1 : '0);
    m_pend = (m_pend & ~clr) | p;
    if (w && a) m_mask = d[NP-1:0];
    if (cons) begin
      m_ptr   = m_sel;
      m_found = 1'b0;
      start   = m_sel;
      resume  = 1'b1;
    end
    if (w && !a && d[1]) m_ptr = NP - 1;
    c = m_pend & m_mask;
    if (m_found && !c[m_sel]) begin
      m_found = 1'b0;
      start   = m_sel;
      resume  = 1'b1;
    end
    if (!m_found) begin
      if (!resume) start = m_ptr;
      j = rr_first(c, start);
      if (j >= 0) begin
        m_found = 1'b1;
        m_sel   = j;
      end
    end
  endfunction

  function automatic exp_t m_read(string nm, bit a);
    exp_t e;
    e.name = nm;
    e.data = '0;
    e.irq  = m_found;
    if (!a) begin
      e.data[4:0] = m_sel[4:0];
      e.data[31]  = m_found;
    end else begin
      e.data[NP-1:0] = m_pend;
      e.data[31]     = |m_ovf;
    end
    return e;
  endfunction

  task automatic do_op(input string nm, input bit r, input bit w,
                       input bit a, input logic [31:0] d,
                       input logic [NP-1:0] p);
    @(posedge clk);
    #1;
    if (r) exp_q.push_back(m_read(nm, a));
    rd = r; wr = w; addr = a; data_in = d; proc_rdy = p;
    @(posedge clk);
    #1;
    rd = 0; wr = 0; addr = 0; data_in = '0; proc_rdy = '0;
    m_apply(r, w, a, d, p);
    repeat (SETTLE) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1; rd = 0; wr = 0; addr = 0;
    data_in = '0; proc_rdy = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    m_reset();
  endtask

  always @(negedge clk) begin
    if (rd === 1'b1) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read: data_out=%h with no expectation",
                 data_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        if (data_out !== e.data || irq !== e.irq) begin
          errors++;
          $display("FAIL %s: data_out=%h irq=%b expected data_out=%h irq=%b",
                   e.name, data_out, irq, e.data, e.irq);
        end
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    bit          got;
    int          k;
    logic [31:0] d;
    logic [NP-1:0] p;
    rst = 1; rd = 0; wr = 0; addr = 0;
    data_in = '0; proc_rdy = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    m_reset();

    do_op("reset_next", 1, 0, 0, 0, '0);
    do_op("reset_status", 1, 0, 1, 0, '0);

    // line 3 held for two cycles, irq within 5 cycles of capture
    do_op("mask_all", 0, 1, 1, 32'hFFFF, '0);
    @(posedge clk);
    #1 proc_rdy = 16'h0008;
    @(posedge clk);
    got = 1'b0;
    n   = 0;
    for (int i = 1; i <= NP + 4 && !got; i++) begin
      @(negedge clk);
      if (i == 2) proc_rdy = '0;
      if (irq) begin
        got = 1'b1;
        n   = i - 1;
      end
    end
    checks++;
    if (!got || n > 5) begin
      errors++;
      $display("FAIL irq_latency: got=%0d cycles=%0d required<=5",
               got, n);
    end
    m_apply(0, 0, 0, 0, 16'h0008);
    repeat (SETTLE) @(posedge clk);
    do_op("next_3", 1, 0, 0, 0, '0);
    do_op("status_after_3", 1, 0, 1, 0, '0);

    // 2, 5, 9 from ptr = 15
    do_op("rst_ptr", 0, 1, 0, 32'h2, '0);
    do_op("pend_259", 0, 0, 0, 0, 16'h0224);
    do_op("next_2", 1, 0, 0, 0, '0);
    do_op("next_5", 1, 0, 0, 0, '0);
    do_op("next_9", 1, 0, 0, 0, '0);
    do_op("next_empty", 1, 0, 0, 0, '0);

    // only enabled line 4 served
    do_op("mask_10", 0, 1, 1, 32'h0010, '0);
    do_op("pend_1_4", 0, 0, 0, 0, 16'h0012);
    do_op("status_12", 1, 0, 1, 0, '0);
    do_op("next_4", 1, 0, 0, 0, '0);
    do_op("status_02", 1, 0, 1, 0, '0);
    do_op("next_masked", 1, 0, 0, 0, '0);

    // mask drop in FOUND on sel 7
    do_op("clr_rst", 0, 1, 0, 32'h3, '0);
    do_op("mask_all2", 0, 1, 1, 32'hFFFF, '0);
    do_op("pend_7", 0, 0, 0, 0, 16'h0080);
    do_op("next_peek7", 1, 0, 1, 0, '0);
    do_op("pend_10", 0, 0, 0, 0, 16'h0400);
    do_op("mask_no7", 0, 1, 1, 32'hFF7F, '0);
    do_op("status_7_10", 1, 0, 1, 0, '0);
    do_op("next_10", 1, 0, 0, 0, '0);
    do_op("mask_all3", 0, 1, 1, 32'hFFFF, '0);
    do_op("next_7", 1, 0, 0, 0, '0);

    // edge on 6 during its consuming read
    do_op("clr_rst2", 0, 1, 0, 32'h3, '0);
    do_op("pend_6_8", 0, 0, 0, 0, 16'h0140);
    do_op("next_6_edge", 1, 0, 0, 0, 16'h0040);
    do_op("next_8", 1, 0, 0, 0, '0);
    do_op("next_6_again", 1, 0, 0, 0, '0);

    // overflow and its clear; clear-all racing an edge
    do_op("clr_all_ovf", 0, 1, 0, 32'h7, '0);
    do_op("pend_0a", 0, 0, 0, 0, 16'h0001);
    do_op("pend_0b", 0, 0, 0, 0, 16'h0001);
    do_op("status_ovf", 1, 0, 1, 0, '0);
    do_op("clr_ovf", 0, 1, 0, 32'h4, '0);
    do_op("status_noovf", 1, 0, 1, 0, '0);
    do_op("clr_vs_edge", 0, 1, 0, 32'h1, 16'h0020);
    do_op("status_edge_wins", 1, 0, 1, 0, '0);

    // read and mask write together see pre-write state
    do_op("rdwr_status", 1, 1, 1, 32'h0003, '0);
    do_op("next_after_rdwr", 1, 0, 0, 0, '0);

    // reset while in FOUND
    do_op("mask_all4", 0, 1, 1, 32'hFFFF, 16'h1100);
    do_reset();
    do_op("rst_mid_next", 1, 0, 0, 0, '0);
    do_op("rst_mid_status", 1, 0, 1, 0, '0);
    do_op("masked_after_rst", 0, 0, 0, 0, 16'h0004);
    do_op("next_masked_rst", 1, 0, 0, 0, '0);

    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 9);
      p = ($urandom_range(0, 2) == 0) ?
          NP'($urandom & $urandom & $urandom) : '0;
      case (k)
        0, 1, 2: do_op("rnd_next", 1, 0, 0, 0, p);
        3, 4:    do_op("rnd_status", 1, 0, 1, 0, p);
        5: begin
          d = $urandom_range(0, 1) ? 32'hFFFF : $urandom;
          do_op("rnd_mask", 0, 1, 1, d, p);
        end
        6: begin
          d = 32'($urandom_range(0, 7));
          do_op("rnd_ctrl", 0, 1, 0, d, p);
        end
        9: begin
          d = $urandom_range(0, 1) ? 32'hFFFF : $urandom;
          do_op("rnd_rdwr", 1, 1, 1, d, p);
        end
        default: do_op("rnd_pulse", 0, 0, 0, 0, p);
      endcase
    end

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d reads never observed, required 0",
               exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
